score_overlay: RTL and testbench

Per-player score keeper and seven-segment pixel renderer for the pong video pipeline. Counts points for player 1 and player 2 from hit events. Converts each score to two decimal digits and reports, for the current VGA pixel coordinate, whether that pixel lies on a lit segment of any of the four on-screen digits. It sits between the game state logic, which supplies hit events and clear, and the RGB mux, which paints `seg_on` white.

---
 rtl/score_pkg.sv | 47 ++++
 rtl/seg_digit_render.sv | 23 ++
 rtl/score_overlay.sv | 69 ++++++
 tb/tb_score_overlay.sv | 137 +++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// score_pkg: digit geometry, segment codes and default digit origins for the score overlay.
package score_pkg;
  localparam int DIG_W = 24;
  localparam int DIG_H = 40;
  localparam int STROKE = 4;
  localparam int MID_Y = 18;
  localparam int HALF_H = 22;
  localparam int RIGHT_X = DIG_W - STROKE;
  localparam logic [9:0] DEF_SCORE_Y = 10'd25;
  localparam logic [9:0] DEF_P1_TENS_X = 10'd242;
  localparam logic [9:0] DEF_P1_ONES_X = 10'd276;
  localparam logic [9:0] DEF_P2_TENS_X = 10'd340;
  localparam logic [9:0] DEF_P2_ONES_X = 10'd374;
  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h70;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h7B;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0: return SEG_0;
      4'd1: return SEG_1;
      4'd2: return SEG_2;
      4'd3: return SEG_3;
      4'd4: return SEG_4;
      4'd5: return SEG_5;
      4'd6: return SEG_6;
      4'd7: return SEG_7;
      4'd8: return SEG_8;
      4'd9: return SEG_9;
      default: return 7'h00;
    endcase
  endfunction

  // 11-bit so origin + offset near 1023 cannot wrap
  function automatic logic in_span(input logic [9:0] v, input logic [9:0] org, input int off, input int len);
    logic [10:0] lo;
    lo = {1'b0, org} + 11'(off);
    return ({1'b0, v} >= lo) && ({1'b0, v} < lo + 11'(len));
  endfunction
endpackage

// File: rtl/seg_digit_render.sv
// seg_digit_render: combinational hit test of one seven-segment digit at a given origin.
module seg_digit_render
  import score_pkg::*;
(
  input  logic [9:0] org_x_i,
  input  logic [9:0] org_y_i,
  input  logic [3:0] digit_i,
  input  logic [9:0] x_i,
  input  logic [9:0] y_i,
  output logic       hit_o
);
  logic [6:0] on;
  always_comb begin
    on[6] = in_span(x_i, org_x_i, 0, DIG_W) && in_span(y_i, org_y_i, 0, STROKE);
    on[5] = in_span(x_i, org_x_i, RIGHT_X, STROKE) && in_span(y_i, org_y_i, 0, HALF_H);
    on[4] = in_span(x_i, org_x_i, RIGHT_X, STROKE) && in_span(y_i, org_y_i, MID_Y, DIG_H - MID_Y);
    on[3] = in_span(x_i, org_x_i, 0, DIG_W) && in_span(y_i, org_y_i, DIG_H - STROKE, STROKE);
    on[2] = in_span(x_i, org_x_i, 0, STROKE) && in_span(y_i, org_y_i, MID_Y, DIG_H - MID_Y);
    on[1] = in_span(x_i, org_x_i, 0, STROKE) && in_span(y_i, org_y_i, 0, HALF_H);
    on[0] = in_span(x_i, org_x_i, 0, DIG_W) && in_span(y_i, org_y_i, MID_Y, STROKE);
    hit_o = |(seg_code(digit_i) & on);
  end
endmodule

// File: rtl/score_overlay.sv
// score_overlay: two saturating point counters and a registered four-digit seven-segment pixel mask.
module score_overlay
  import score_pkg::*;
#(
  parameter logic [9:0] SCORE_Y = DEF_SCORE_Y,
  parameter logic [9:0] P1_TENS_X = DEF_P1_TENS_X,
  parameter logic [9:0] P1_ONES_X = DEF_P1_ONES_X,
  parameter logic [9:0] P2_TENS_X = DEF_P2_TENS_X,
  parameter logic [9:0] P2_ONES_X = DEF_P2_ONES_X
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       p1_point,
  input  logic       p2_point,
  input  logic       score_clear,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [4:0] score_p1,
  output logic [4:0] score_p2,
  output logic       seg_on
);
  logic       p1_q, p2_q, seg_q, seg_d;
  logic [4:0] s1_q, s2_q, s1_d, s2_d;
  logic [3:0] t1, o1, t2, o2;
  logic [3:0] hit;

  function automatic logic [3:0] tens_of(input logic [4:0] s);
    return s >= 5'd30 ? 4'd3 : s >= 5'd20 ? 4'd2 : s >= 5'd10 ? 4'd1 : 4'd0;
  endfunction

  function automatic logic [3:0] ones_of(input logic [4:0] s);
    return 4'(s >= 5'd30 ? s - 5'd30 : s >= 5'd20 ? s - 5'd20 : s >= 5'd10 ? s - 5'd10 : s);
  endfunction

  always_comb begin
    s1_d = score_clear ? 5'd0 : (p1_point && !p1_q && s1_q != 5'd31) ? s1_q + 5'd1 : s1_q;
    s2_d = score_clear ? 5'd0 : (p2_point && !p2_q && s2_q != 5'd31) ? s2_q + 5'd1 : s2_q;
    t1 = tens_of(s1_q);
    o1 = ones_of(s1_q);
    t2 = tens_of(s2_q);
    o2 = ones_of(s2_q);
    seg_d = |hit;
  end

  seg_digit_render u_p1t (.org_x_i(P1_TENS_X), .org_y_i(SCORE_Y), .digit_i(t1), .x_i(x), .y_i(y), .hit_o(hit[0]));
  seg_digit_render u_p1o (.org_x_i(P1_ONES_X), .org_y_i(SCORE_Y), .digit_i(o1), .x_i(x), .y_i(y), .hit_o(hit[1]));
  seg_digit_render u_p2t (.org_x_i(P2_TENS_X), .org_y_i(SCORE_Y), .digit_i(t2), .x_i(x), .y_i(y), .hit_o(hit[2]));
  seg_digit_render u_p2o (.org_x_i(P2_ONES_X), .org_y_i(SCORE_Y), .digit_i(o2), .x_i(x), .y_i(y), .hit_o(hit[3]));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1_q <= 1'b0;
      p2_q <= 1'b0;
      s1_q <= 5'd0;
      s2_q <= 5'd0;
      seg_q <= 1'b0;
    end else begin
      p1_q <= p1_point;
      p2_q <= p2_point;
      s1_q <= s1_d;
      s2_q <= s2_d;
      seg_q <= seg_d;
    end
  end

  assign score_p1 = s1_q;
  assign score_p2 = s2_q;
  assign seg_on = seg_q;
endmodule

// File: tb/tb_score_overlay.sv
// tb_score_overlay: scoreboard bench for score_overlay counting, clear, saturation and pixel decode.
module tb_score_overlay;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       p1_point = 1'b0, p2_point = 1'b0, score_clear = 1'b0;
  logic [9:0] x = 10'd0, y = 10'd0;
  logic [4:0] score_p1, score_p2;
  logic       seg_on;
  int n_cmp = 0, n_bad = 0;
  int m1 = 0, m2 = 0;
  logic pr1 = 1'b0, pr2 = 1'b0;

  typedef struct {
    string tag;
    int    sel;
    int    exp;
  } exp_t;
  exp_t sb[$];

  score_overlay dut (
    .clk(clk), .reset_n(reset_n), .p1_point(p1_point), .p2_point(p2_point),
    .score_clear(score_clear), .x(x), .y(y),
    .score_p1(score_p1), .score_p2(score_p2), .seg_on(seg_on)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc();
    exp_t e;
    if (score_clear) begin
      m1 = 0;
      m2 = 0;
    end else begin
      if (p1_point && !pr1 && m1 < 31) m1++;
      if (p2_point && !pr2 && m2 < 31) m2++;
    end
    pr1 = p1_point;
    pr2 = p2_point;
    sb.push_back('{"score_p1", 0, m1});
    sb.push_back('{"score_p2", 1, m2});
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, e.sel == 0 ? int'(score_p1) : e.sel == 1 ? int'(score_p2) : int'(seg_on), e.exp);
    end
  endtask

  task automatic pix(input int px, input int py, input int exp, input string tag);
    x = 10'(px);
    y = 10'(py);
    sb.push_back('{tag, 2, exp});
    cyc();
  endtask

  task automatic pulse1(input int hi, input int lo);
    p1_point = 1'b1;
    repeat (hi) cyc();
    p1_point = 1'b0;
    repeat (lo) cyc();
  endtask

  task automatic pulse2(input int hi, input int lo);
    p2_point = 1'b1;
    repeat (hi) cyc();
    p2_point = 1'b0;
    repeat (lo) cyc();
  endtask

  initial begin
    #1;
    check("rst_p1", score_p1, 0);
    check("rst_p2", score_p2, 0);
    check("rst_seg", seg_on, 0);
    #20 reset_n = 1'b1;
    @(posedge clk);
    #1;
    pix(242, 25, 1, "rst_a0");
    pix(252, 35, 0, "rst_interior");
    repeat (3) pulse1(3, 2);
    check("count_p1", score_p1, 3);
    check("count_p2", score_p2, 0);
    p1_point = 1'b1;
    p2_point = 1'b1;
    cyc();
    p1_point = 1'b0;
    p2_point = 1'b0;
    cyc();
    check("simul_p1", score_p1, 4);
    check("simul_p2", score_p2, 1);
    repeat (35) pulse2(1, 1);
    check("sat_p2", score_p2, 31);
    pix(340, 25, 1, "sat_tens3_a");
    pix(374, 25, 0, "sat_ones1_a");
    pix(394, 30, 1, "sat_ones1_b");
    pulse1(1, 1);
    check("pre_clear_p1", score_p1, 5);
    p1_point = 1'b1;
    score_clear = 1'b1;
    cyc();
    score_clear = 1'b0;
    p1_point = 1'b0;
    cyc();
    check("clear_p1", score_p1, 0);
    check("clear_p2", score_p2, 0);
    repeat (10) pulse1(1, 1);
    check("ten_p1", score_p1, 10);
    pix(262, 30, 1, "dec_tens1_b");
    pix(242, 30, 0, "dec_tens1_f");
    pix(276, 45, 1, "dec_ones0_e");
    pix(276, 64, 1, "dec_ones0_d");
    pix(288, 44, 0, "dec_ones0_g");
    pix(363, 25, 1, "edge_x23");
    pix(364, 25, 0, "edge_x24");
    pix(340, 64, 1, "edge_y39");
    pix(340, 65, 0, "edge_y40");
    pix(340, 24, 0, "edge_y_above");
    pix(1023, 1023, 0, "far_corner");
    pulse1(1, 1);
    pulse2(1, 1);
    #3 reset_n = 1'b0;
    #1;
    check("midrst_p1", score_p1, 0);
    check("midrst_p2", score_p2, 0);
    check("midrst_seg", seg_on, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
